bin_to_bcd_converter: RTL and testbench



---
 rtl/bin_to_bcd_converter.sv | 130 +++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter.sv
// ============================================================================
// Module      : bin_to_bcd_converter
// Description : Sequential double-dabble binary to 4-digit BCD converter,
//               saturating at 9999 with an overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_converter #(
   parameter int WIDTH = 14
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Binary,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output logic [3:0]       BCD3,
   output logic [3:0]       BCD2,
   output logic [3:0]       BCD1,
   output logic [3:0]       BCD0
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]          r_state;
   logic [0:0]          w_next_state;
   logic [CNT_W-1:0]    r_count;
   logic [WIDTH-1:0]    r_operand;
   logic [15:0]         r_scratch;
   logic                r_ovf_pending;

   logic                w_accept;
   logic                w_final;
   logic                w_ovf;
   logic [WIDTH-1:0]    w_load;
   logic [15:0]         w_adj;
   logic [WIDTH+15:0]   w_shifted;

   assign w_accept = (r_state == ST_IDLE) && Start;
   assign w_final  = (r_state == ST_SHIFT) && (r_count == CNT_W'(1));

   // Narrow inputs can never exceed 9999, so the compare only exists when it can fire.
   generate
      if (WIDTH >= 14) begin : g_sat
         localparam logic [WIDTH-1:0] C_MAX = WIDTH'(9999);
         assign w_ovf  = (Binary > C_MAX);
         assign w_load = w_ovf ? C_MAX : Binary;
      end else begin : g_no_sat
         assign w_ovf  = 1'b0;
         assign w_load = Binary;
      end
   endgenerate

   generate
      for (genvar i = 0; i < 4; i++) begin : g_nib
         assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                                  (r_scratch[4*i +: 4] + 4'd3) :
                                  r_scratch[4*i +: 4];
      end
   endgenerate

   assign w_shifted = {w_adj, r_operand} << 1;

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (Start)   w_next_state = ST_SHIFT;
         ST_SHIFT: if (w_final) w_next_state = ST_IDLE;
         default:               w_next_state = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      Busy = (r_state == ST_SHIFT);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count       <= '0;
         r_operand     <= '0;
         r_scratch     <= '0;
         r_ovf_pending <= 1'b0;
         Done          <= 1'b0;
         Overflow      <= 1'b0;
         BCD3          <= 4'd0;
         BCD2          <= 4'd0;
         BCD1          <= 4'd0;
         BCD0          <= 4'd0;
      end else begin
         Done <= 1'b0;
         if (w_accept) begin
            r_operand     <= w_load;
            r_ovf_pending <= w_ovf;
            r_scratch     <= '0;
            r_count       <= CNT_W'(WIDTH);
         end else if (r_state == ST_SHIFT) begin
            r_scratch <= w_shifted[WIDTH +: 16];
            r_operand <= w_shifted[WIDTH-1:0];
            r_count   <= r_count - CNT_W'(1);
            if (w_final) begin
               BCD3     <= w_shifted[WIDTH+12 +: 4];
               BCD2     <= w_shifted[WIDTH+8  +: 4];
               BCD1     <= w_shifted[WIDTH+4  +: 4];
               BCD0     <= w_shifted[WIDTH    +: 4];
               Overflow <= r_ovf_pending;
               Done     <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
// ============================================================================
// Module      : tb_bin_to_bcd_converter
// Description : Directed vector bench for bin_to_bcd_converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_converter;

   localparam int WIDTH = 14;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             Start;
   logic [WIDTH-1:0] Binary;
   logic             Busy;
   logic             Done;
   logic             Overflow;
   logic [3:0]       BCD3, BCD2, BCD1, BCD0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [WIDTH-1:0] bin;
      logic [15:0]      bcd;
      logic             ovf;
   } vec_t;

   vec_t vecs [8];

   bin_to_bcd_converter #(.WIDTH(WIDTH)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Binary   (Binary),
      .Busy     (Busy),
      .Done     (Done),
      .Overflow (Overflow),
      .BCD3     (BCD3),
      .BCD2     (BCD2),
      .BCD1     (BCD1),
      .BCD0     (BCD0)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic int digits();
      return int'({BCD3, BCD2, BCD1, BCD0});
   endfunction

   // Called in the cycle after the accepting edge; returns cycles to Done and Busy-high cycles.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = -1;
      busy_cnt = Busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (Done) begin
            lat = k;
            break;
         end
         if (Busy) busy_cnt++;
      end
   endtask

   task automatic convert(input logic [WIDTH-1:0] b, output int lat, output int busy_cnt);
      Binary = b;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      wait_done(lat, busy_cnt);
   endtask

   initial begin
      int lat, busy_cnt, dones, busy_seen;

      vecs[0] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
      vecs[1] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
      vecs[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
      vecs[3] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
      vecs[4] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
      vecs[5] = '{bin: 14'd42,    bcd: 16'h0042, ovf: 1'b0};
      vecs[6] = '{bin: 14'd1,     bcd: 16'h0001, ovf: 1'b0};
      vecs[7] = '{bin: 14'd5090,  bcd: 16'h5090, ovf: 1'b0};

      Reset  = 1'b1;
      Start  = 1'b0;
      Binary = '0;
      repeat (3) tick();
      Reset = 1'b0;

      // Idle after reset: nothing moves
      dones = 0;
      busy_seen = 0;
      repeat (20) begin
         tick();
         if (Done) dones++;
         if (Busy) busy_seen++;
      end
      check("idle_done", dones, 0);
      check("idle_busy", busy_seen, 0);
      check("idle_digits", digits(), 0);
      check("idle_ovf", int'(Overflow), 0);

      foreach (vecs[i]) begin
         convert(vecs[i].bin, lat, busy_cnt);
         check($sformatf("vec%0d_latency", i), lat, WIDTH);
         check($sformatf("vec%0d_busy_cycles", i), busy_cnt, WIDTH);
         check($sformatf("vec%0d_busy_at_done", i), int'(Busy), 0);
         check($sformatf("vec%0d_digits", i), digits(), int'(vecs[i].bcd));
         check($sformatf("vec%0d_ovf", i), int'(Overflow), int'(vecs[i].ovf));
         tick();
         check($sformatf("vec%0d_done_pulse", i), int'(Done), 0);
         check($sformatf("vec%0d_hold_digits", i), digits(), int'(vecs[i].bcd));
      end

      // Start during Busy is ignored
      Binary = 14'd5678;
      Start  = 1'b1;
      tick();
      dones = 0;
      lat   = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 3) begin
            Start  = 1'b1;
            Binary = 14'd1111;
         end else begin
            Start  = 1'b0;
         end
         tick();
         if (Done) begin
            dones++;
            if (lat < 0) begin
               lat = k;
               check("ignore_digits", digits(), 16'h5678);
            end
         end
      end
      check("ignore_latency", lat, WIDTH);
      check("ignore_done_count", dones, 1);

      // Start held: re-trigger on each Done cycle
      Binary = 14'd100;
      Start  = 1'b1;
      tick();
      wait_done(lat, busy_cnt);
      check("held1_latency", lat, WIDTH);
      check("held1_busy_at_done", int'(Busy), 0);
      check("held1_digits", digits(), 16'h0100);
      Binary = 14'd200;
      tick();
      check("held2_busy_after_accept", int'(Busy), 1);
      wait_done(lat, busy_cnt);
      Start = 1'b0;
      check("held2_latency", lat, WIDTH);
      check("held2_busy_cycles", busy_cnt, WIDTH);
      check("held2_digits", digits(), 16'h0200);
      tick();
      check("held2_idle_busy", int'(Busy), 0);

      // Reset aborts a conversion in flight
      convert(14'd4321, lat, busy_cnt);
      check("pre_abort_digits", digits(), 16'h4321);
      Binary = 14'd8765;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      dones  = 0;
      repeat (6) begin
         tick();
         if (Done) dones++;
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort_digits", digits(), 0);
      check("abort_busy", int'(Busy), 0);
      check("abort_ovf", int'(Overflow), 0);
      repeat (20) begin
         tick();
         if (Done) dones++;
      end
      check("abort_no_done", dones, 0);
      convert(14'd8765, lat, busy_cnt);
      check("post_abort_latency", lat, WIDTH);
      check("post_abort_digits", digits(), 16'h8765);

      // Reset wins over Start
      Reset  = 1'b1;
      Start  = 1'b1;
      Binary = 14'd42;
      tick();
      check("reset_prio_busy", int'(Busy), 0);
      check("reset_prio_digits", digits(), 0);
      Reset = 1'b0;
      Start = 1'b0;
      tick();
      check("reset_prio_idle", int'(Busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
